uart_rx_if: RTL and testbench

UART_RX_IF -- requirements
Module: uart_rx_if

---
 rtl/uart_rx_if_pkg.sv | 18 +
 rtl/mod_m_counter.sv | 23 ++
 rtl/uart_rx_if_fifo.sv | 47 ++++
 rtl/uart_rx_if.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_if.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_if_pkg.sv
// Shared UART definitions: bus width, receiver FSM states and
// status-word bit positions (also used by the TX side).
package uart_rx_if_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_FERR  = 3;
  localparam int STAT_W     = 4;
endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter with a one-cycle pulse on the
// terminal count.
module mod_m_counter #(
  parameter int M = 326,
  parameter int N = 9
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_max_tick
);
  logic [N-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= '0;
    else if (r_q == N'(M - 1))
      r_q <= '0;
    else
      r_q <= r_q + 1'b1;
  end

  assign o_max_tick = (r_q == N'(M - 1));
endmodule

// File: rtl/uart_rx_if_fifo.sv
// Receive FIFO: extra pointer bit separates full from empty; a
// pop on empty yields zero.
module uart_rx_fifo #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [B-1:0] i_wdata,
  output logic [B-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_ovr
);
  logic [B-1:0] r_mem [0:(1<<W)-1];
  logic [W:0]   r_wptr;
  logic [W:0]   r_rptr;
  logic         w_do_wr;
  logic         w_do_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[W] != r_rptr[W]) &&
                   (r_wptr[W-1:0] == r_rptr[W-1:0]);
  assign w_do_rd = i_rd & ~o_empty;
  assign w_do_wr = i_wr & (~o_full | i_rd);
  assign o_ovr   = i_wr & o_full & ~i_rd;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[W-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_wr)
      r_mem[r_wptr[W-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_do_rd)
        r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_if.sv
// UART receiver with 16x oversampling, RX FIFO and a memory-mapped
// read port (bit 2 of the address selects data or status).
module uart_rx_if
  import uart_rx_if_pkg::*;
#(
  parameter logic [8:0] DIVISOR       = 9'd326,
  parameter logic [3:0] DVSR_BIT      = 4'd9,
  parameter logic [3:0] DATA_BIT      = 4'd8,
  parameter logic [4:0] SB_TCK        = 5'd16,
  parameter int         FIFO_ADDR_BIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_rx,
  input  logic            uart_en,
  input  logic            mem_rd_en,
  input  logic [XLEN-1:0] uart_addr,
  input  logic            uart_rx_en,
  output logic [XLEN-1:0] uart_rd_data,
  output logic            rx_fifo_empty,
  output logic            rx_fifo_full
);
  uart_state_e         r_state, w_state_nx;
  logic [3:0]          r_s, w_s_nx;
  logic [2:0]          r_n, w_n_nx;
  logic [DATA_BIT-1:0] r_b, w_b_nx;
  logic                r_sync1, r_sync2;
  logic                r_ovr, r_ferr;
  logic [XLEN-1:0]     r_rd_data;
  logic                w_rx, w_tck, w_push, w_ferr;
  logic                w_rd, w_pop, w_stat_rd, w_fifo_ovr;
  logic [DATA_BIT-1:0] w_fifo_rdata;
  logic [STAT_W-1:0]   w_status;
  logic                w_unused_addr;

  assign w_rx          = r_sync2;
  assign w_rd          = uart_en & mem_rd_en;
  assign w_pop         = w_rd & ~uart_addr[2];
  assign w_stat_rd     = w_rd & uart_addr[2];
  assign uart_rd_data  = r_rd_data;
  assign w_unused_addr = ^{uart_addr[XLEN-1:3], uart_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  mod_m_counter #(
    .M (int'(DIVISOR)),
    .N (int'(DVSR_BIT))
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_max_tick (w_tck)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_b_nx     = r_b;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_rx && uart_rx_en) begin
          w_state_nx = ST_START;
          w_s_nx     = '0;
        end
      end
      ST_START: begin
        if (w_tck) begin
          if (r_s == 4'd7) begin
            w_state_nx = w_rx ? ST_IDLE : ST_DATA;
            w_s_nx     = '0;
            w_n_nx     = '0;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tck) begin
          if (r_s == 4'd15) begin
            w_s_nx = '0;
            w_b_nx = {w_rx, r_b[DATA_BIT-1:1]};
            if (r_n == 3'(DATA_BIT - 4'd1))
              w_state_nx = ST_STOP;
            else
              w_n_nx = r_n + 1'b1;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tck) begin
          if (r_s == 4'(SB_TCK - 5'd1)) begin
            w_push     = w_rx;
            w_ferr     = ~w_rx;
            w_state_nx = ST_IDLE;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .B (int'(DATA_BIT)),
    .W (FIFO_ADDR_BIT)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_push),
    .i_rd    (w_pop),
    .i_wdata (r_b),
    .o_rdata (w_fifo_rdata),
    .o_empty (rx_fifo_empty),
    .o_full  (rx_fifo_full),
    .o_ovr   (w_fifo_ovr)
  );

  always_comb begin
    w_status             = '0;
    w_status[STAT_EMPTY] = rx_fifo_empty;
    w_status[STAT_FULL]  = rx_fifo_full;
    w_status[STAT_OVR]   = r_ovr;
    w_status[STAT_FERR]  = r_ferr;
  end

  // A new error in the clearing cycle wins over the status-read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_fifo_ovr)
        r_ovr <= 1'b1;
      else if (w_stat_rd)
        r_ovr <= 1'b0;
      if (w_ferr)
        r_ferr <= 1'b1;
      else if (w_stat_rd)
        r_ferr <= 1'b0;
      if (w_rd)
        r_rd_data <= uart_addr[2] ? XLEN'(w_status)
                                  : XLEN'(w_fifo_rdata);
    end
  end
endmodule

// File: tb/tb_uart_rx_if.sv
// Directed bench for uart_rx_if with a byte scoreboard and a
// model of the sticky error flags.
module tb_uart_rx_if;
  import uart_rx_if_pkg::*;

  localparam int DIV = 4;
  localparam int BIT = DIV * 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_en = 1'b0;
  logic        mem_rd_en = 1'b0;
  logic [31:0] uart_addr = '0;
  logic        uart_rx_en = 1'b0;
  logic [31:0] uart_rd_data;
  logic        rx_fifo_empty;
  logic        rx_fifo_full;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sb_q[$];
  logic        m_ovr = 1'b0;
  logic        m_ferr = 1'b0;
  logic        seen;
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  uart_rx_if #(
    .DIVISOR (9'd4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (uart_rx),
    .uart_en       (uart_en),
    .mem_rd_en     (mem_rd_en),
    .uart_addr     (uart_addr),
    .uart_rx_en    (uart_rx_en),
    .uart_rd_data  (uart_rd_data),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_full  (rx_fifo_full)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] d, input logic stop);
    if (!stop)
      m_ferr = 1'b1;
    else if (sb_q.size() == 16)
      m_ovr = 1'b1;
    else
      sb_q.push_back(d);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input logic gate);
    @(negedge clk) uart_rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    if (gate) uart_rx_en = 1'b0;
    repeat (BIT - BIT / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT) @(negedge clk);
    model_push(d, stop);
    if (gate) uart_rx_en = 1'b1;
  endtask

  task automatic do_read(input logic a2);
    @(negedge clk);
    uart_en   = 1'b1;
    mem_rd_en = 1'b1;
    uart_addr = a2 ? 32'h8000_0004 : 32'h8000_00f8;
    @(negedge clk);
    uart_en   = 1'b0;
    mem_rd_en = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] e;
    e = (sb_q.size() > 0) ? {24'b0, sb_q.pop_front()} : 32'h0;
    do_read(1'b0);
    chk(tag, uart_rd_data, e);
  endtask

  task automatic rd_stat(input string tag);
    logic [31:0] e;
    e = {28'b0, m_ferr, m_ovr,
         1'(sb_q.size() == 16), 1'(sb_q.size() == 0)};
    do_read(1'b1);
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    chk(tag, uart_rd_data, e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rd_data", uart_rd_data, 32'h0);
    chk("rst_empty", 32'(rx_fifo_empty), 32'h1);
    chk("rst_full", 32'(rx_fifo_full), 32'h0);
    rst_n = 1'b1;
    uart_rx_en = 1'b1;
    repeat (4) @(negedge clk);
    rd_stat("stat_idle");

    send_frame(8'h55, 1'b1, 1'b0);
    chk("empty_after_55", 32'(rx_fifo_empty), 32'h0);
    rd_data("data_55");
    repeat (3) @(negedge clk);
    chk("hold_55", uart_rd_data, 32'h0000_0055);
    chk("empty_after_pop", 32'(rx_fifo_empty), 32'h1);

    send_frame(8'hA3, 1'b0, 1'b1);
    rd_stat("stat_ferr");
    rd_stat("stat_ferr_clr");

    @(negedge clk) uart_rx = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * BIT) @(negedge clk);
    rd_stat("stat_glitch");
    send_frame(8'hA5, 1'b1, 1'b0);
    rd_data("data_a5");

    @(negedge clk) uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = 1'b1;
      if (i == 4) begin
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_data", uart_rd_data, 32'h0);
        sb_q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT / 2 - 3) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    repeat (2 * BIT) @(negedge clk);
    chk("midrst_empty", 32'(rx_fifo_empty), 32'h1);
    send_frame(8'h3C, 1'b1, 1'b0);
    rd_data("data_3c");
    rd_data("pop_empty");
    chk("pop_empty_flag", 32'(rx_fifo_empty), 32'h1);

    for (int k = 0; k < 17; k++)
      send_frame(8'(k), 1'b1, 1'b0);
    chk("full_17", 32'(rx_fifo_full), 32'h1);
    rd_stat("stat_ovr");
    for (int k = 0; k < 16; k++)
      rd_data($sformatf("drain_%0d", k));
    chk("drain_empty", 32'(rx_fifo_empty), 32'h1);
    rd_stat("stat_drained");

    for (int k = 0; k < 16; k++)
      send_frame(8'h20 + 8'(k), 1'b1, 1'b0);
    chk("full_again", 32'(rx_fifo_full), 32'h1);
    seen = 1'b0;
    fork
      send_frame(8'h30, 1'b1, 1'b0);
      begin
        for (int c = 0; c < 20 * BIT && !seen; c++) begin
          @(negedge clk);
          if (dut.w_push) seen = 1'b1;
        end
        chk("push_seen", 32'(seen), 32'h1);
        if (seen) begin
          exp_v = {24'b0, sb_q.pop_front()};
          uart_en   = 1'b1;
          mem_rd_en = 1'b1;
          uart_addr = 32'h0;
          @(negedge clk);
          uart_en   = 1'b0;
          mem_rd_en = 1'b0;
          chk("pop_at_push", uart_rd_data, exp_v);
        end
      end
    join
    chk("full_kept", 32'(rx_fifo_full), 32'h1);
    rd_stat("stat_no_ovr");
    for (int k = 0; k < 16; k++)
      rd_data($sformatf("order_%0d", k));
    chk("final_empty", 32'(rx_fifo_empty), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
